// File: rtl/fp16_pkg.sv
// fp16_pkg
// Shared IEEE-754 half-precision (FP16) definitions for the pooling datapath.
// Contents: field widths and bit positions, the canonical quiet NaN that
// replaces any NaN operand, and an is_nan() classifier.
package fp16_pkg;

    localparam int FP16_WIDTH = 16;
    localparam int SIGN_BIT   = 15;
    localparam int EXP_MSB    = 14;
    localparam int EXP_LSB    = 10;
    localparam int MANT_MSB   = 9;
    localparam int MANT_LSB   = 0;
    localparam int EXP_WIDTH  = EXP_MSB - EXP_LSB + 1;
    localparam int MANT_WIDTH = MANT_MSB - MANT_LSB + 1;

    localparam logic [EXP_WIDTH-1:0]  EXP_ALL_ONES  = '1;
    localparam logic [FP16_WIDTH-1:0] CANONICAL_NAN = 16'h7E00;

    // NaN: exponent saturated and a non-zero mantissa (Inf has mantissa 0).
    function automatic logic is_nan(input logic [FP16_WIDTH-1:0] value);
        return (value[EXP_MSB:EXP_LSB] == EXP_ALL_ONES) &&
               (value[MANT_MSB:MANT_LSB] != '0);
    endfunction

endpackage

// File: rtl/fp16_max2.sv
// fp16_max2
// Combinational two-input FP16 maximum under true numeric order.
//   lhs    : operand with the lower tile index; it wins all ties
//   rhs    : operand with the higher tile index
//   maxOut : exact bit pattern of the larger operand, or CANONICAL_NAN if
//            either operand is NaN
// +0 and -0 compare equal, so a tie between them keeps lhs.
module fp16_max2
    import fp16_pkg::*;
(
    input  logic [FP16_WIDTH-1:0] lhs,
    input  logic [FP16_WIDTH-1:0] rhs,
    output logic [FP16_WIDTH-1:0] maxOut
);

    logic [FP16_WIDTH-2:0] lhsMag;
    logic [FP16_WIDTH-2:0] rhsMag;
    logic                  lhsNeg;
    logic                  rhsNeg;
    logic                  bothZero;
    logic                  rhsWins;

    assign lhsMag   = lhs[EXP_MSB:0];
    assign rhsMag   = rhs[EXP_MSB:0];
    assign lhsNeg   = lhs[SIGN_BIT];
    assign rhsNeg   = rhs[SIGN_BIT];
    assign bothZero = (lhsMag == '0) && (rhsMag == '0);

    // rhsWins is set only when rhs is strictly greater than lhs.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
        rhsWins = 1'b0;
        maxOut  = lhs;
        if (bothZero) begin
            rhsWins = 1'b0;                 // signed zeros are equal
        end else if (lhsNeg != rhsNeg) begin
            rhsWins = lhsNeg;               // the positive operand wins
        end else if (!lhsNeg) begin
            rhsWins = (rhsMag > lhsMag);    // positives: larger magnitude wins
        end else begin
            rhsWins = (rhsMag < lhsMag);    // negatives: smaller magnitude wins
        end

        if (rhsWins) begin
            maxOut = rhs;
        end
        if (is_nan(lhs) || is_nan(rhs)) begin
            maxOut = CANONICAL_NAN;
        end
    end

endmodule

// File: rtl/max_pool_single5.sv
// max_pool_single5
// Single-window 5x5 FP16 max-pooling stage (window = stride = 5), one result
// per channel, registered with one cycle of latency.
//   clk      : rising-edge clock
//   reset    : asynchronous active-high reset; clears mPoolOut to 0x0000
//   mPoolIn  : packed tile; element (r, c, d) at index k = (r*InputW + c)*Depth + d,
//              bits [k*16+15 : k*16], k = 0 at the LSB
//   mPoolOut : channel d maximum at bits [d*16+15 : d*16]
// Each channel is reduced by a tree of fp16_max2 units (25->13->7->4->2->1).
// Pairs are formed from adjacent lower/higher indices with the lower index on
// the left, so the first-occurring maximum survives every level.
module max_pool_single5
    import fp16_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int InputH     = 5,
    parameter int InputW     = 5,
    parameter int Depth      = 1,
    localparam int s         = 5
)
(
    input  logic                                                clk,
    input  logic                                                reset,
    input  logic [InputH*InputW*Depth*DATA_WIDTH-1:0]           mPoolIn,
    output logic [(InputH/s)*(InputW/s)*Depth*DATA_WIDTH-1:0]   mPoolOut
);

    localparam int NUM_ELEMS = InputH * InputW;
    localparam int OUT_W     = (InputH/s) * (InputW/s) * Depth * DATA_WIDTH;

    // Number of nodes on tree level lv (level 0 holds the leaves).
    function automatic int levelCount(input int lv);
        int n;
        n = NUM_ELEMS;
        for (int i = 0; i < lv; i++) begin
            n = (n + 1) / 2;
        end
        return n;
    endfunction

    // Position of the first node of level lv in the flattened node array.
    function automatic int levelOffset(input int lv);
        int off;
        off = 0;
        for (int i = 0; i < lv; i++) begin
            off += levelCount(i);
        end
        return off;
    endfunction

    // Levels including the leaf level and the single root level.
    function automatic int numLevels();
        int n;
        int lv;
        n  = NUM_ELEMS;
        lv = 1;
        while (n > 1) begin
            n  = (n + 1) / 2;
            lv = lv + 1;
        end
        return lv;
    endfunction

    localparam int NUM_LEVELS  = numLevels();
    localparam int TOTAL_NODES = levelOffset(NUM_LEVELS);
    localparam int ROOT_NODE   = levelOffset(NUM_LEVELS - 1);

    logic [OUT_W-1:0] pooled;

    for (genvar d = 0; d < Depth; d++) begin : gChannel
        logic [TOTAL_NODES-1:0][DATA_WIDTH-1:0] node;

        for (genvar e = 0; e < NUM_ELEMS; e++) begin : gLeaf
            assign node[e] = mPoolIn[(e*Depth + d)*DATA_WIDTH +: DATA_WIDTH];
        end

        for (genvar lv = 0; lv < NUM_LEVELS - 1; lv++) begin : gLevel
            localparam int IN_CNT  = levelCount(lv);
            localparam int OUT_CNT = levelCount(lv + 1);
            localparam int IN_OFF  = levelOffset(lv);
            localparam int OUT_OFF = levelOffset(lv + 1);

            for (genvar j = 0; j < OUT_CNT; j++) begin : gNode
                if (2*j + 1 < IN_CNT) begin : gPair
                    fp16_max2 uMax (
                        .lhs    (node[IN_OFF + 2*j]),
                        .rhs    (node[IN_OFF + 2*j + 1]),
                        .maxOut (node[OUT_OFF + j])
                    );
                end else begin : gPass
                    // Odd node out: forwarded unchanged; it meets a comparator
                    // on a later level, where any NaN gets canonicalised.
                    assign node[OUT_OFF + j] = node[IN_OFF + 2*j];
                end
            end
        end

        assign pooled[d*DATA_WIDTH +: DATA_WIDTH] = node[ROOT_NODE];
    end

    // Output register: every edge loads a new result; no other state exists.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
            mPoolOut <= '0;
        end else begin
            mPoolOut <= pooled;
        end
    end

endmodule

// File: tb/tb_max_pool_single5.sv
// tb_max_pool_single5
// Self-checking bench for max_pool_single5. Expected results come from a
// reference model that converts FP16 patterns to real numbers and scans the
// tile for the first strictly-greatest value, with NaN overriding.
module tb_max_pool_single5;

    localparam int DW     = 16;
    localparam int NELEM  = 25;
    localparam int IN_W   = NELEM * DW;
    localparam int OUT_W  = DW;

    logic              clk;
    logic              reset;
    logic [IN_W-1:0]   mPoolIn;
    logic [OUT_W-1:0]  mPoolOut;

    int total;
    int bad;

    max_pool_single5 dut (
        .clk      (clk),
        .reset    (reset),
        .mPoolIn  (mPoolIn),
        .mPoolOut (mPoolOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic isNanPat(input logic [15:0] v);
        return (v[14:10] == 5'h1F) && (v[9:0] != 10'h0);
    endfunction

    function automatic real fp16ToReal(input logic [15:0] v);
        real mag;
        int  e;
        e = int'(v[14:10]);
        if (e == 31) begin
            mag = 1.0e30;                       // infinity, above every finite FP16
        end else if (e == 0) begin
            mag = real'(v[9:0]) / 16777216.0;   // mant * 2^-24
        end else begin
            mag = real'(1024 + int'(v[9:0]));
            for (int i = 25; i < e; i++) mag = mag * 2.0;
            for (int i = e; i < 25; i++) mag = mag / 2.0;
        end
        return v[15] ? -mag : mag;
    endfunction

    function automatic logic [15:0] modelMax(input logic [IN_W-1:0] tile);
        logic [15:0] best;
        logic [15:0] cur;
        real         bestVal;
        best    = tile[15:0];
        bestVal = fp16ToReal(best);
        for (int k = 0; k < NELEM; k++) begin
            if (isNanPat(tile[k*DW +: DW])) return 16'h7E00;
        end
        for (int k = 1; k < NELEM; k++) begin
            cur = tile[k*DW +: DW];
            if (fp16ToReal(cur) > bestVal) begin
                best    = cur;
                bestVal = fp16ToReal(cur);
            end
        end
        return best;
    endfunction

    function automatic logic [IN_W-1:0] fillTile(input logic [15:0] v);
        logic [IN_W-1:0] t;
        for (int k = 0; k < NELEM; k++) t[k*DW +: DW] = v;
        return t;
    endfunction

    // Random FP16 element biased toward finite values, with occasional specials.
    function automatic logic [15:0] randElem();
        logic [15:0] v;
        int          r;
        r = $urandom_range(0, 19);
        v = 16'($urandom);
        if (r == 0) begin
            case ($urandom_range(0, 5))
                0: v = 16'h7C00;
                1: v = 16'hFC00;
                2: v = 16'h0000;
                3: v = 16'h8000;
                4: v = 16'h7D00;
                default: v = 16'h0001;
            endcase
        end else if (v[14:10] == 5'h1F) begin
            v[14] = 1'b0;
        end
        return v;
    endfunction

    // Present a tile at the falling edge and let the next rising edge load it.
    task automatic applyTile(input logic [IN_W-1:0] tile);
        @(negedge clk);
        mPoolIn = tile;
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [IN_W-1:0] t;
        @(negedge clk);
        mPoolIn = fillTile(16'h4500);
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (mPoolOut !== 16'h0000) begin
            bad++;
            $display("FAIL reset_async: got %h want 0000", mPoolOut);
        end
        @(posedge clk);
        #1;
        total++;
        if (mPoolOut !== 16'h0000) begin
            bad++;
            $display("FAIL reset_held: got %h want 0000", mPoolOut);
        end
        @(negedge clk);
        reset = 1'b0;
        t = fillTile(16'h4000);
        applyTile(t);
        total++;
        if (mPoolOut !== 16'h4000) begin
            bad++;
            $display("FAIL reset_first_edge: got %h want 4000", mPoolOut);
        end
    endtask

    task automatic test_single_peak();
        logic [IN_W-1:0] t;
        t = fillTile(16'h4000);
        t[4*DW +: DW] = 16'h4200;
        applyTile(t);
        total++;
        if (mPoolOut !== 16'h4200) begin
            bad++;
            $display("FAIL single_peak: got %h want 4200", mPoolOut);
        end
        // Output is registered: changing the input mid-cycle must not move it.
        @(negedge clk);
        mPoolIn = fillTile(16'h4400);
        #1;
        total++;
        if (mPoolOut !== 16'h4200) begin
            bad++;
            $display("FAIL output_stable: got %h want 4200", mPoolOut);
        end
    endtask

    task automatic test_mixed_signs();
        logic [IN_W-1:0] t;
        logic [15:0]     upper [8];
        upper = '{16'hBC00, 16'hC000, 16'hC200, 16'hC400,
                  16'hC000, 16'hC200, 16'hC400, 16'hC500};
        t = fillTile(16'h4200);
        for (int i = 0; i < 8; i++) t[(24 - i)*DW +: DW] = upper[i];
        t[16*DW +: DW] = 16'h4400;
        t[0 +: DW]     = 16'h4500;
        applyTile(t);
        total++;
        if (mPoolOut !== 16'h4500 || modelMax(t) !== 16'h4500) begin
            bad++;
            $display("FAIL mixed_signs: got %h want 4500", mPoolOut);
        end
        t[0 +: DW] = 16'h4200;
        applyTile(t);
        total++;
        if (mPoolOut !== 16'h4400) begin
            bad++;
            $display("FAIL mixed_signs_next: got %h want 4400", mPoolOut);
        end
    endtask

    task automatic test_all_negative();
        logic [IN_W-1:0] t;
        t = fillTile(16'hC600);
        t[3*DW +: DW]  = 16'hC500;
        t[7*DW +: DW]  = 16'hC400;
        t[11*DW +: DW] = 16'hC200;
        t[18*DW +: DW] = 16'hBC00;
        t[22*DW +: DW] = 16'hC000;
        applyTile(t);
        total++;
        if (mPoolOut !== 16'hBC00) begin
            bad++;
            $display("FAIL all_negative: got %h want BC00", mPoolOut);
        end
        t = fillTile(16'h8000);
        for (int k = 0; k < NELEM; k += 2) t[k*DW +: DW] = 16'h0000;
        t[13*DW +: DW] = 16'h0001;
        applyTile(t);
        total++;
        if (mPoolOut !== 16'h0001) begin
            bad++;
            $display("FAIL subnormal: got %h want 0001", mPoolOut);
        end
    endtask

    task automatic test_specials();
        logic [IN_W-1:0] t;
        int              pos;
        t = fillTile(16'h7BFF);
        t[20*DW +: DW] = 16'h7C00;
        applyTile(t);
        total++;
        if (mPoolOut !== 16'h7C00) begin
            bad++;
            $display("FAIL plus_inf: got %h want 7C00", mPoolOut);
        end
        for (int n = 0; n < 3; n++) begin
            pos = (n == 0) ? 24 : int'($urandom_range(0, NELEM - 1));
            t = fillTile(16'h7C00);
            t[pos*DW +: DW] = 16'h7D00;
            applyTile(t);
            total++;
            if (mPoolOut !== 16'h7E00) begin
                bad++;
                $display("FAIL nan_at_k%0d: got %h want 7E00", pos, mPoolOut);
            end
        end
        t = fillTile(16'h0000);
        t[0 +: DW] = 16'h8000;
        applyTile(t);
        total++;
        if (mPoolOut !== 16'h8000) begin
            bad++;
            $display("FAIL neg_zero_first: got %h want 8000", mPoolOut);
        end
        t = fillTile(16'h8000);
        t[0 +: DW] = 16'h0000;
        applyTile(t);
        total++;
        if (mPoolOut !== 16'h0000) begin
            bad++;
            $display("FAIL pos_zero_first: got %h want 0000", mPoolOut);
        end
        t = fillTile(16'hFC00);
        applyTile(t);
        total++;
        if (mPoolOut !== 16'hFC00) begin
            bad++;
            $display("FAIL all_minus_inf: got %h want FC00", mPoolOut);
        end
    endtask

    task automatic test_random();
        logic [IN_W-1:0] t;
        logic [15:0]     expected;
        int              src;
        for (int n = 0; n < 300; n++) begin
            for (int k = 0; k < NELEM; k++) begin
                t[k*DW +: DW] = randElem();
                // Plant duplicates and signed-zero twins to exercise ties.
                if (k > 0 && $urandom_range(0, 7) == 0) begin
                    src = int'($urandom_range(0, k - 1));
                    t[k*DW +: DW] = t[src*DW +: DW];
                end
            end
            expected = modelMax(t);
            applyTile(t);
            total++;
            if (mPoolOut !== expected) begin
                bad++;
                $display("FAIL random_%0d: got %h want %h", n, mPoolOut, expected);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [IN_W-1:0] tiles [4];
        logic [15:0]     expected [4];
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < NELEM; k++) tiles[i][k*DW +: DW] = {1'b0, randElem() & 16'h3FFF};
            tiles[i][(i*5 + 2)*DW +: DW] = 16'h5000 + 16'(i);
            expected[i] = modelMax(tiles[i]);
        end
        applyTile(tiles[0]);
        total++;
        if (mPoolOut !== expected[0]) begin
            bad++;
            $display("FAIL b2b_0: got %h want %h", mPoolOut, expected[0]);
        end
        // New input at the falling edge must not show until the next rise.
        @(negedge clk);
        mPoolIn = tiles[1];
        #1;
        total++;
        if (mPoolOut !== expected[0]) begin
            bad++;
            $display("FAIL b2b_latency: got %h want %h", mPoolOut, expected[0]);
        end
        @(posedge clk);
        #1;
        total++;
        if (mPoolOut !== expected[1]) begin
            bad++;
            $display("FAIL b2b_1: got %h want %h", mPoolOut, expected[1]);
        end
        // Reset pulse between two edges discards the held result.
        @(negedge clk);
        mPoolIn = tiles[2];
        reset   = 1'b1;
        #1;
        total++;
        if (mPoolOut !== 16'h0000) begin
            bad++;
            $display("FAIL b2b_reset_pulse: got %h want 0000", mPoolOut);
        end
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (mPoolOut !== expected[2]) begin
            bad++;
            $display("FAIL b2b_after_reset: got %h want %h", mPoolOut, expected[2]);
        end
        applyTile(tiles[3]);
        total++;
        if (mPoolOut !== expected[3]) begin
            bad++;
            $display("FAIL b2b_3: got %h want %h", mPoolOut, expected[3]);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b0;
        mPoolIn = '0;
        test_reset();
        test_single_peak();
        test_mixed_signs();
        test_all_negative();
        test_specials();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
